// File: rtl/tcb_arb_pkg.sv
// Shared types and helpers for the TCB round-robin arbiter family.
package tcb_arb_pkg;

    localparam int unsigned MN_MAX = 8;
    localparam int unsigned IW_MAX = 3;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic              found;
        logic [IW_MAX-1:0] idx;
    } pick_t;

    function automatic int unsigned idx_width(input int unsigned mn);
        return (mn > 1) ? $clog2(mn) : 1;
    endfunction

    // First set bit of req at or above ptr, wrapping modulo mn.
    function automatic pick_t rr_pick(input logic [MN_MAX-1:0] req,
                                      input logic [IW_MAX-1:0] ptr,
                                      input int unsigned       mn);
        pick_t       r;
        int unsigned k;
        r = '0;
        for (int unsigned i = 0; i < MN_MAX; i++) begin
            if (i < mn) begin
                k = 32'(ptr) + i;
                if (k >= mn) begin
                    k = k - mn;
                end
                if (!r.found && req[k]) begin
                    r.found = 1'b1;
                    r.idx   = k[IW_MAX-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/tcb_arb_rr_pri.sv
// Rotating priority encoder: picks the first requester at or above ptr_i.
module tcb_arb_rr_pri
    import tcb_arb_pkg::*;
#(
    parameter int unsigned MN = 2,
    parameter int unsigned IW = idx_width(MN)
) (
    input  logic [MN-1:0] req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [MN-1:0] gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [MN_MAX-1:0] req_x;
    logic [IW_MAX-1:0] ptr_x;
    pick_t             pick;

    always_comb begin
        req_x          = '0;
        req_x[MN-1:0]  = req_i;
        ptr_x          = '0;
        ptr_x[IW-1:0]  = ptr_i;
        pick           = rr_pick(req_x, ptr_x, MN);
        idx_o          = pick.idx[IW-1:0];
        any_o          = pick.found;
        gnt_o          = '0;
        for (int unsigned i = 0; i < MN; i++) begin
            gnt_o[i] = pick.found && (32'(pick.idx) == i);
        end
    end

endmodule

// File: rtl/tcb_arb_rr.sv
// Round-robin TCB arbiter: MN managers share one fixed-delay subordinate.
// Optional manager lock for atomic sequences: define TCB_ARB_RR_LOCK_EN.
module tcb_arb_rr
    import tcb_arb_pkg::*;
#(
    parameter int unsigned MN  = 2,
    parameter int unsigned AW  = 32,
    parameter int unsigned DW  = 32,
    parameter int unsigned DLY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [MN-1:0]    m_vld,
    input  logic [MN-1:0]    m_wen,
    input  logic [MN*AW-1:0] m_adr,
    input  logic [MN*DW-1:0] m_wdt,
`ifdef TCB_ARB_RR_LOCK_EN
    input  logic [MN-1:0]    m_lck,
`endif
    output logic [MN-1:0]    m_rdy,
    output logic [MN-1:0]    m_err,
    output logic [MN-1:0]    m_rsp,
    output logic [DW-1:0]    m_rdt,
    output logic             s_vld,
    output logic             s_wen,
    output logic [AW-1:0]    s_adr,
    output logic [DW-1:0]    s_wdt,
    input  logic             s_rdy,
    input  logic             s_err,
    input  logic [DW-1:0]    s_rdt
);

    localparam int unsigned IW = idx_width(MN);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] hidx_q, hidx_d;
    logic          lck_q, lck_d;

    logic [MN-1:0] pri_gnt;
    logic [IW-1:0] pri_idx;
    logic          pri_any;
    logic [IW-1:0] cur_idx;
    logic [MN-1:0] gnt;
    logic          xfer;
    logic          lck_xfer;
    logic          rsp_v;
    logic [IW-1:0] rsp_idx;

    tcb_arb_rr_pri #(
        .MN (MN),
        .IW (IW)
    ) u_pri (
        .req_i (m_vld),
        .ptr_i (ptr_q),
        .gnt_o (pri_gnt),
        .idx_o (pri_idx),
        .any_o (pri_any)
    );

    // In HOLD the registered index owns the bus; vld of that manager alone qualifies it.
    always_comb begin
        cur_idx = (state_q == HOLD) ? hidx_q : pri_idx;
        gnt     = pri_gnt;
        if (state_q == HOLD) begin
            gnt = '0;
            for (int unsigned i = 0; i < MN; i++) begin
                gnt[i] = m_vld[i] && (32'(hidx_q) == i);
            end
        end
        s_vld = (state_q == HOLD) ? |gnt : pri_any;
        xfer  = s_vld & s_rdy;
    end

    always_comb begin
        s_wen = 1'b0;
        s_adr = '0;
        s_wdt = '0;
        for (int unsigned i = 0; i < MN; i++) begin
            if (gnt[i]) begin
                s_wen = m_wen[i];
                s_adr = m_adr[i*AW +: AW];
                s_wdt = m_wdt[i*DW +: DW];
            end
        end
        m_rdy = gnt & {MN{s_rdy}};
        m_err = gnt & {MN{s_err}};
        m_rdt = s_rdt;
    end

`ifdef TCB_ARB_RR_LOCK_EN
    always_comb lck_xfer = |(gnt & m_lck);
`else
    always_comb lck_xfer = 1'b0;
`endif

    // A locked transfer behaves like a stall for grant purposes but leaves ptr alone.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hidx_d  = hidx_q;
        lck_d   = lck_q;
        if (xfer) begin
            if (lck_xfer) begin
                state_d = HOLD;
                hidx_d  = cur_idx;
                lck_d   = 1'b1;
            end else begin
                state_d = ARB;
                lck_d   = 1'b0;
                ptr_d   = (32'(cur_idx) == MN - 1) ? '0 : cur_idx + IW'(1);
            end
        end else if (s_vld) begin
            state_d = HOLD;
            hidx_d  = cur_idx;
        end else if (state_q == HOLD && !lck_q) begin
            state_d = ARB;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB;
            ptr_q   <= '0;
            hidx_q  <= '0;
            lck_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hidx_q  <= hidx_d;
            lck_q   <= lck_d;
        end
    end

    a_hold_vld: assert property (@(posedge clk) disable iff (!rst)
        (state_q == HOLD && !lck_q) |-> s_vld);

    if (DLY == 0) begin : g_rsp_comb
        always_comb begin
            rsp_v   = xfer & ~s_wen;
            rsp_idx = cur_idx;
        end
    end else begin : g_rsp_pipe
        logic [DLY-1:0] pv_q;
        logic [IW-1:0]  pi_q [DLY];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pv_q <= '0;
                for (int unsigned i = 0; i < DLY; i++) begin
                    pi_q[i] <= '0;
                end
            end else begin
                pv_q[0] <= xfer & ~s_wen;
                pi_q[0] <= cur_idx;
                for (int unsigned i = 1; i < DLY; i++) begin
                    pv_q[i] <= pv_q[i-1];
                    pi_q[i] <= pi_q[i-1];
                end
            end
        end

        always_comb begin
            rsp_v   = pv_q[DLY-1];
            rsp_idx = pi_q[DLY-1];
        end
    end

    always_comb begin
        m_rsp = '0;
        for (int unsigned i = 0; i < MN; i++) begin
            m_rsp[i] = rsp_v && (32'(rsp_idx) == i);
        end
    end

endmodule

// File: tb/tb_tcb_arb_rr.sv
// Bench for tcb_arb_rr: DLY=1 and DLY=3 instances on shared stimulus, checked by a behavioural model.
module tb_tcb_arb_rr;

    localparam int MN = 2;

    logic          clk;
    logic          rst;
    logic [1:0]    m_vld, m_wen;
    logic [63:0]   m_adr, m_wdt;
    logic          s_rdy, s_err;
    logic [31:0]   s_rdt;
`ifdef TCB_ARB_RR_LOCK_EN
    logic [1:0]    m_lck, lck_nxt;
`endif

    logic [1:0]  a_rdy, a_err, a_rsp, b_rdy, b_err, b_rsp;
    logic [31:0] a_rdt, b_rdt, a_adr, b_adr, a_wdt, b_wdt;
    logic        a_vld, b_vld, a_wen, b_wen;

    int total = 0;
    int bad   = 0;

    tcb_arb_rr #(.MN(2), .AW(32), .DW(32), .DLY(1)) u_dut1 (
        .clk(clk), .rst(rst), .m_vld(m_vld), .m_wen(m_wen), .m_adr(m_adr), .m_wdt(m_wdt),
`ifdef TCB_ARB_RR_LOCK_EN
        .m_lck(m_lck),
`endif
        .m_rdy(a_rdy), .m_err(a_err), .m_rsp(a_rsp), .m_rdt(a_rdt),
        .s_vld(a_vld), .s_wen(a_wen), .s_adr(a_adr), .s_wdt(a_wdt),
        .s_rdy(s_rdy), .s_err(s_err), .s_rdt(s_rdt)
    );

    tcb_arb_rr #(.MN(2), .AW(32), .DW(32), .DLY(3)) u_dut3 (
        .clk(clk), .rst(rst), .m_vld(m_vld), .m_wen(m_wen), .m_adr(m_adr), .m_wdt(m_wdt),
`ifdef TCB_ARB_RR_LOCK_EN
        .m_lck(m_lck),
`endif
        .m_rdy(b_rdy), .m_err(b_err), .m_rsp(b_rsp), .m_rdt(b_rdt),
        .s_vld(b_vld), .s_wen(b_wen), .s_adr(b_adr), .s_wdt(b_wdt),
        .s_rdy(s_rdy), .s_err(s_err), .s_rdt(s_rdt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: grant by rotating scan, hold on stall or lock, read strobe after DLY cycles.
    int mptr = 0, mhidx = 0;
    bit mhold = 0, mlck = 0;
    int hist [4] = '{-1, -1, -1, -1};

    always @(negedge clk) begin : model
        int          g, j;
        logic        e_vld, e_wen, lk, xf;
        logic [31:0] e_adr, e_wdt;
        logic [1:0]  e_rdy, e_err, e_r1, e_r3;
        if (!rst) begin
            mptr = 0; mhold = 0; mhidx = 0; mlck = 0;
            for (int i = 0; i < 4; i++) hist[i] = -1;
        end
        g = -1;
        if (mhold) begin
            if (m_vld[mhidx]) g = mhidx;
        end else begin
            for (int k = 0; k < MN; k++) begin
                j = (mptr + k) % MN;
                if (g < 0 && m_vld[j]) g = j;
            end
        end
        e_vld = (g >= 0);
        e_wen = 1'b0; e_adr = '0; e_wdt = '0; e_rdy = '0; e_err = '0; lk = 1'b0;
        if (g >= 0) begin
            e_wen = m_wen[g];
            e_adr = m_adr[g*32 +: 32];
            e_wdt = m_wdt[g*32 +: 32];
            e_rdy = s_rdy ? 2'(1 << g) : 2'b00;
            e_err = s_err ? 2'(1 << g) : 2'b00;
`ifdef TCB_ARB_RR_LOCK_EN
            lk = m_lck[g];
`endif
        end
        e_r1 = (hist[0] < 0) ? 2'b00 : 2'(1 << hist[0]);
        e_r3 = (hist[2] < 0) ? 2'b00 : 2'(1 << hist[2]);

        chk("s_vld", a_vld, e_vld);    chk("d3 s_vld", b_vld, e_vld);
        chk("s_wen", a_wen, e_wen);    chk("d3 s_wen", b_wen, e_wen);
        chk("s_adr", a_adr, e_adr);    chk("d3 s_adr", b_adr, e_adr);
        chk("s_wdt", a_wdt, e_wdt);    chk("d3 s_wdt", b_wdt, e_wdt);
        chk("m_rdy", a_rdy, e_rdy);    chk("d3 m_rdy", b_rdy, e_rdy);
        chk("m_err", a_err, e_err);    chk("d3 m_err", b_err, e_err);
        chk("m_rsp", a_rsp, e_r1);     chk("d3 m_rsp", b_rsp, e_r3);
        chk("m_rdt", a_rdt, s_rdt);    chk("d3 m_rdt", b_rdt, s_rdt);

        xf = e_vld && s_rdy;
        for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = (rst && xf && !e_wen) ? g : -1;
        if (rst) begin
            if (xf) begin
                if (lk) begin
                    mhold = 1; mhidx = g; mlck = 1;
                end else begin
                    mhold = 0; mlck = 0; mptr = (g + 1) % MN;
                end
            end else if (e_vld) begin
                mhold = 1; mhidx = g;
            end else if (mhold && !mlck) begin
                mhold = 0;
            end
        end
    end

    task automatic step(input logic r, input logic [1:0] vld, input logic [1:0] wen,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic rdy, input logic err);
        @(posedge clk);
        #1;
        rst   = r;
        m_vld = vld;
        m_wen = wen;
        m_adr = {a1, a0};
        m_wdt = {d1, d0};
        s_rdy = rdy;
        s_err = err;
        s_rdt = $urandom;
`ifdef TCB_ARB_RR_LOCK_EN
        m_lck = lck_nxt;
`endif
        @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b0; m_vld = '0; m_wen = '0; m_adr = '0; m_wdt = '0;
        s_rdy = 1'b1; s_err = 1'b0; s_rdt = '0;
`ifdef TCB_ARB_RR_LOCK_EN
        m_lck = '0; lck_nxt = '0;
`endif
        // reset, idle and with requests pending
        step(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0);
        chk("rst s_vld", a_vld, 1'b0);
        chk("rst m_rdy", a_rdy, 2'b00);
        chk("rst m_rsp", a_rsp, 2'b00);
        step(0, 2'b11, 2'b00, 32'h8, 32'h8, 0, 0, 1, 0);
        chk("rst req m_rdy", a_rdy, 2'b01);
        step(1, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0);

        // both managers read continuously: grants alternate
        for (int c = 0; c < 4; c++) begin
            step(1, 2'b11, 2'b00, 32'h8, 32'h8, 0, 0, 1, 0);
            chk("alt m_rdy", a_rdy, (c % 2 == 0) ? 2'b01 : 2'b10);
            chk("alt s_adr", a_adr, 32'h8);
            chk("alt m_rsp", a_rsp, (c == 0) ? 2'b00 : ((c % 2 == 1) ? 2'b01 : 2'b10));
        end
        step(1, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0);
        chk("alt last m_rsp", a_rsp, 2'b10);

        // single requester writes back to back
        step(1, 2'b10, 2'b10, 0, 32'h0, 0, 32'hA5, 1, 0);
        chk("wr1 m_rdy", a_rdy, 2'b10);
        chk("wr1 s_adr", a_adr, 32'h0);
        chk("wr1 s_wdt", a_wdt, 32'hA5);
        chk("wr1 s_wen", a_wen, 1'b1);
        step(1, 2'b10, 2'b10, 0, 32'h4, 0, 32'hFF, 1, 0);
        chk("wr2 m_rdy", a_rdy, 2'b10);
        chk("wr2 s_adr", a_adr, 32'h4);
        chk("wr2 s_wdt", a_wdt, 32'hFF);
        chk("wr2 m_rsp", a_rsp, 2'b00);
        step(1, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0);
        chk("wr idle m_rsp", a_rsp, 2'b00);

        // stall: manager 0 granted, manager 1 joins, grant must not move
        step(1, 2'b01, 2'b00, 32'h10, 0, 0, 0, 0, 0);
        chk("stall s_vld", a_vld, 1'b1);
        chk("stall s_adr", a_adr, 32'h10);
        chk("stall m_rdy", a_rdy, 2'b00);
        for (int c = 0; c < 2; c++) begin
            step(1, 2'b11, 2'b00, 32'h10, 32'h20, 0, 0, 0, 0);
            chk("hold s_adr", a_adr, 32'h10);
            chk("hold m_rdy", a_rdy, 2'b00);
        end
        step(1, 2'b11, 2'b00, 32'h10, 32'h20, 0, 0, 1, 0);
        chk("release m_rdy", a_rdy, 2'b01);
        chk("release s_adr", a_adr, 32'h10);
        step(1, 2'b11, 2'b00, 32'h10, 32'h20, 0, 0, 1, 0);
        chk("next m_rdy", a_rdy, 2'b10);
        chk("next s_adr", a_adr, 32'h20);
        chk("next m_rsp", a_rsp, 2'b01);
        step(1, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0);
        chk("next idle m_rsp", a_rsp, 2'b10);

        // error routed only in the transfer cycle
        step(1, 2'b10, 2'b10, 0, 32'h8, 0, 32'h1, 1, 1);
        chk("err m_err", a_err, 2'b10);
        chk("err m_rdy", a_rdy, 2'b10);
        step(1, 2'b00, 2'b00, 0, 0, 0, 0, 1, 1);
        chk("err idle m_err", a_err, 2'b00);
        for (int c = 0; c < 3; c++) step(1, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0);

        // reset drops an in-flight DLY=3 read
        step(1, 2'b10, 2'b00, 0, 32'hC, 0, 0, 1, 0);
        chk("inflight m_rdy", b_rdy, 2'b10);
        step(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0);
        chk("rst d1 m_rsp", a_rsp, 2'b00);
        chk("rst d3 m_rsp", b_rsp, 2'b00);
        for (int c = 0; c < 3; c++) begin
            step(1, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0);
            chk("dropped d3 m_rsp", b_rsp, 2'b00);
        end

        // ptr returns to 0 on reset even after a grant moved it
        step(1, 2'b01, 2'b01, 32'h40, 0, 32'h7, 0, 1, 0);
        chk("pre-rst m_rdy", a_rdy, 2'b01);
        step(0, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0);
        step(1, 2'b11, 2'b00, 32'h44, 32'h48, 0, 0, 1, 0);
        chk("post-rst m_rdy", a_rdy, 2'b01);
        chk("post-rst s_adr", a_adr, 32'h44);
        step(1, 2'b10, 2'b00, 0, 32'h4C, 0, 0, 1, 0);
        chk("post-rst next m_rdy", a_rdy, 2'b10);

`ifdef TCB_ARB_RR_LOCK_EN
        // locked sequence: manager 0 keeps the bus for three transfers
        lck_nxt = 2'b01;
        step(1, 2'b11, 2'b11, 32'h30, 32'h50, 1, 2, 1, 0);
        chk("lock1 m_rdy", a_rdy, 2'b01);
        step(1, 2'b11, 2'b11, 32'h34, 32'h50, 3, 2, 1, 0);
        chk("lock2 m_rdy", a_rdy, 2'b01);
        lck_nxt = 2'b00;
        step(1, 2'b11, 2'b11, 32'h38, 32'h50, 5, 2, 1, 0);
        chk("lock3 m_rdy", a_rdy, 2'b01);
        step(1, 2'b11, 2'b11, 32'h38, 32'h50, 5, 2, 1, 0);
        chk("unlock m_rdy", a_rdy, 2'b10);
        chk("unlock s_adr", a_adr, 32'h50);
`endif

        step(1, 2'b00, 2'b00, 0, 0, 0, 0, 1, 0);
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tcb_arb_rr.md
Name: tcb_arb_rr

Overview:
- Round-robin arbiter that lets MN TCB managers (CPU data port, debug module, DMA) share one TCB subordinate, such as the GPIO controller or another peripheral with fixed response delay.
- Muxes request fields from the granted manager and routes handshake and error back to it.
- Tracks in-flight reads so delayed read data is strobed only to the manager that issued the read.

Parameters:
- MN, 2, number of managers (2..8)
- AW, 32, address width
- DW, 32, data width
- DLY, 1, subordinate read-data delay in cycles after transfer (0..4)

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low (asserted when 0)
- m_vld  input  MN  manager request valid
- m_wen  input  MN  manager write enable
- m_adr  input  MN*AW  manager address, packed, manager i at [i*AW+:AW]
- m_wdt  input  MN*DW  manager write data, packed
- m_rdy  output  MN  manager ready
- m_err  output  MN  manager error
- m_rsp  output  MN  read-data strobe, one-hot, DLY cycles after read transfer
- m_rdt  output  DW  read data, shared by all managers, qualified by m_rsp
- s_vld  output  1  subordinate valid
- s_wen  output  1  subordinate write enable
- s_adr  output  AW  subordinate address
- s_wdt  output  DW  subordinate write data
- s_rdy  input  1  subordinate ready
- s_err  input  1  subordinate error, request phase
- s_rdt  input  DW  subordinate read data

Behaviour:
- Transfer: s_vld & s_rdy.
- Grant selection:
  - Combinational when FSM is in ARB.
  - First requester found scanning from ptr upward, wrapping modulo MN.
  - ptr resets to 0.
  - On each transfer, ptr <= granted index + 1, wrapping MN-1 -> 0.
- Mux and routing:
  - s_vld = |m_vld while in ARB. s_wen/s_adr/s_wdt are taken from the granted manager; all zero when none is granted.
  - m_rdy[i] = s_rdy & gnt[i]; m_err[i] = s_err & gnt[i].
  - Non-granted managers see rdy=0, err=0.
- FSM:
  - ARB: grant is combinational.
  - HOLD: entered when a granted request is stalled (s_vld & ~s_rdy). The grant index is registered and held, so the grant cannot change mid-stall.
  - HOLD -> ARB on the transfer cycle.
  - Reset state: ARB.
- Managers must keep vld and fields stable while stalled. Dropping vld in HOLD is a protocol violation; it is flagged by a simulation assertion and the FSM returns to ARB.
- Response pipeline:
  - DLY-stage shift register of {valid, index}, loaded with {transfer & ~s_wen, granted index}.
  - m_rsp[idx] = last stage valid.
  - DLY=0: m_rsp is combinational from the current read transfer.
  - m_rdt = s_rdt, passed through unregistered.
- Back-to-back transfers every cycle are supported; pipeline stages never collide.
- Simultaneous requests from all managers: each one is served once per MN transfers (fairness).
- Single requester: granted every cycle, zero bubbles.
- Reset (async assert at any time): ptr=0, FSM=ARB, pipeline cleared.
  - All outputs combinationally follow from these reset state values (all 0 when no requests are pending).
  - In-flight responses are dropped; no m_rsp pulse is issued after reset.

Optional Feature:
- Macro: TCB_ARB_RR_LOCK_EN.
- When defined:
  - Adds input m_lck [MN].
  - If the granted manager has m_lck=1 at transfer, the FSM enters HOLD and keeps the grant for its next request, for atomic read-modify-write on GPIO registers.
  - The lock releases on the first transfer with m_lck=0.
  - ptr updates only on release.
- When undefined: no m_lck port; grant rotates after every transfer.

Decomposition:
- Package tcb_arb_pkg:
  - FSM state enum (ARB, HOLD).
  - Constant IW = (MN > 1) ? $clog2(MN) : 1 for index width.
  - Function rr_pick(req, ptr) returning index and found flag.
- Sub-module tcb_arb_rr_pri: rotating priority encoder (req[MN], ptr[IW] -> gnt one-hot, idx, any). Purely combinational, reused by future DMA channel arbiters.

Test Plan:
- MN=2, DLY=1, s_rdy=1. Both managers read adr 0x8 continuously -> grants alternate 0,1,0,1; m_rsp pulses one cycle after each transfer to the matching manager; m_rdt = s_rdt.
- Manager 1 only, writes 0x0=0xA5 then 0x4=0xFF -> two transfers on consecutive cycles, m_rdy[1]=1 on both, m_rsp stays 0.
- s_rdy=0 for 3 cycles while manager 0 is granted and manager 1 raises vld -> s_adr stays manager 0's address, m_rdy=0 for both; the transfer on cycle 4 goes to manager 0, then manager 1 is granted.
- s_err=1 on a manager 1 write -> m_err=2'b10 in the transfer cycle only.
- DLY=3: read transfer by manager 1, rst pulled low 1 cycle later -> no m_rsp pulse; after release ptr=0 and manager 0 wins a simultaneous request.
- TCB_ARB_RR_LOCK_EN: manager 0 issues 3 transfers with m_lck=1,1,0 while manager 1 requests throughout -> manager 0 receives 3 consecutive grants, then manager 1 is granted.
